// File: rtl/proj1_pkg.sv
// Shared types and constants for the writeback register file: FSM states,
// SREG bit positions and the fixed multiply destination registers.
package proj1_pkg;

  localparam int REG_COUNT = 32;
  localparam int ADDR_W    = 5;

  localparam logic [ADDR_W-1:0] MULT_LO_ADDR = 5'd0;
  localparam logic [ADDR_W-1:0] MULT_HI_ADDR = 5'd1;

  localparam int SREG_C = 0;
  localparam int SREG_Z = 1;
  localparam int SREG_N = 2;

  typedef enum logic {
    IDLE  = 1'b0,
    WR_HI = 1'b1
  } wb_state_e;

endpackage

// File: rtl/proj1_regfile.sv
// 32 x 8-bit flop-based register storage: two combinational read ports,
// one synchronous write port, asynchronous active-low clear.
module proj1_regfile
  import proj1_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] waddr_i,
  input  logic [7:0]        wdata_i,
  input  logic [ADDR_W-1:0] raddr_a_i,
  output logic [7:0]        rdata_a_o,
  input  logic [ADDR_W-1:0] raddr_b_i,
  output logic [7:0]        rdata_b_o
);

  logic [7:0] mem_q [REG_COUNT];

  // NOTE: this array is built from flops, not a RAM macro, so it may take the
  // async clear; a true RAM would need a separate init sequence instead.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < REG_COUNT; i++) begin
        mem_q[i] <= '0;
      end
    end else if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_a_o = mem_q[raddr_a_i];
  assign rdata_b_o = mem_q[raddr_b_i];

endmodule

// File: rtl/proj1_wb_regfile.sv
// ALU writeback register file: 8-bit and two-cycle 16-bit writebacks, read
// bypass from the active write, and the C/Z/N status register.
module proj1_wb_regfile
  import proj1_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] rr_addr,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [7:0]        data_rr,
  output logic [7:0]        data_rd,
  output logic              ci,
  input  logic              wb_valid,
  output logic              wb_ready,
  input  logic [ADDR_W-1:0] wb_addr,
  input  logic              wb_wide,
  input  logic [15:0]       wb_data,
  input  logic              wb_flag_we,
  input  logic              alu_co,
  input  logic              alu_zo,
  input  logic              alu_no,
  output logic [7:0]        sreg
);

  wb_state_e         state_q, state_d;
  logic [7:0]        hi_hold_q, hi_hold_d;
  logic [2:0]        flags_q, flags_d;
  logic              rf_we;
  logic [ADDR_W-1:0] rf_waddr;
  logic [7:0]        rf_wdata;
  logic [7:0]        rf_rr, rf_rd;

  // NOTE: every signal driven here gets a default first, so no path through
  // the case leaves one unassigned and no latch is inferred.
  always_comb begin
    state_d   = state_q;
    hi_hold_d = hi_hold_q;
    flags_d   = flags_q;
    wb_ready  = 1'b0;
    rf_we     = 1'b0;
    rf_waddr  = wb_addr;
    rf_wdata  = wb_data[7:0];
    case (state_q)
      IDLE: begin
        wb_ready = rst;
        if (wb_valid && wb_ready) begin
          rf_we = 1'b1;
          if (wb_wide) begin
            rf_waddr  = MULT_LO_ADDR;
            hi_hold_d = wb_data[15:8];
            state_d   = WR_HI;
          end
          if (wb_flag_we) begin
            flags_d[SREG_C] = alu_co;
            flags_d[SREG_Z] = alu_zo;
            flags_d[SREG_N] = alu_no;
          end
        end
      end
      WR_HI: begin
        // Upstream sees ready low here and holds its next op.
        rf_we    = 1'b1;
        rf_waddr = MULT_HI_ADDR;
        rf_wdata = hi_hold_q;
        state_d  = IDLE;
      end
    endcase
  end

  // NOTE: state registers use non-blocking assignment so every flop samples
  // pre-edge values regardless of block ordering.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      hi_hold_q <= '0;
      flags_q   <= '0;
    end else begin
      state_q   <= state_d;
      hi_hold_q <= hi_hold_d;
      flags_q   <= flags_d;
    end
  end

  proj1_regfile u_regfile (
    .clk       (clk),
    .rst_n     (rst),
    .we_i      (rf_we),
    .waddr_i   (rf_waddr),
    .wdata_i   (rf_wdata),
    .raddr_a_i (rr_addr),
    .rdata_a_o (rf_rr),
    .raddr_b_i (rd_addr),
    .rdata_b_o (rf_rd)
  );

  always_comb begin
    data_rr = '0;
    data_rd = '0;
    if (rst) begin
      data_rr = (rf_we && (rf_waddr == rr_addr)) ? rf_wdata : rf_rr;
      data_rd = (rf_we && (rf_waddr == rd_addr)) ? rf_wdata : rf_rd;
    end
  end

  assign sreg = {5'b0, flags_q};
  assign ci   = flags_q[SREG_C];

endmodule

// File: tb/tb_proj1_wb_regfile.sv
// Self-checking bench: directed scenarios with literal expectations, then
// randomized traffic compared every cycle against a behavioural model.
module tb_proj1_wb_regfile;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [4:0]  rr_addr = '0, rd_addr = '0, wb_addr = '0;
  logic [7:0]  data_rr, data_rd, sreg;
  logic        ci, wb_ready;
  logic        wb_valid = 1'b0, wb_wide = 1'b0, wb_flag_we = 1'b0;
  logic [15:0] wb_data = '0;
  logic        alu_co = 1'b0, alu_zo = 1'b0, alu_no = 1'b0;

  int n_checks = 0;
  int n_fail   = 0;
  bit cmp_en   = 1'b0;

  always #5 clk = ~clk;

  proj1_wb_regfile dut (
    .clk        (clk),
    .rst        (rst),
    .rr_addr    (rr_addr),
    .rd_addr    (rd_addr),
    .data_rr    (data_rr),
    .data_rd    (data_rd),
    .ci         (ci),
    .wb_valid   (wb_valid),
    .wb_ready   (wb_ready),
    .wb_addr    (wb_addr),
    .wb_wide    (wb_wide),
    .wb_data    (wb_data),
    .wb_flag_we (wb_flag_we),
    .alu_co     (alu_co),
    .alu_zo     (alu_zo),
    .alu_no     (alu_no),
    .sreg       (sreg)
  );

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: register contents, status byte, and a queue holding
  // the upper byte of a wide result still owed to R1.
  logic [7:0] m_regs [32];
  logic [7:0] m_sreg;
  logic [7:0] m_pend [$];

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < 32; i++) m_regs[i] = 8'h00;
      m_sreg = 8'h00;
      m_pend.delete();
    end else if (m_pend.size() > 0) begin
      m_regs[1] = m_pend.pop_front();
    end else if (wb_valid) begin
      if (wb_wide) begin
        m_regs[0] = wb_data[7:0];
        m_pend.push_back(wb_data[15:8]);
      end else begin
        m_regs[wb_addr] = wb_data[7:0];
      end
      if (wb_flag_we) m_sreg = {5'b0, alu_no, alu_zo, alu_co};
    end
  end

  function automatic logic [7:0] model_read(input logic [4:0] a);
    logic [7:0] v;
    if (!rst) return 8'h00;
    v = m_regs[a];
    if (m_pend.size() > 0) begin
      if (a == 5'd1) v = m_pend[0];
    end else if (wb_valid) begin
      if (wb_wide && a == 5'd0) v = wb_data[7:0];
      if (!wb_wide && a == wb_addr) v = wb_data[7:0];
    end
    return v;
  endfunction

  always @(negedge clk) begin
    if (cmp_en) begin
      check("cyc_data_rr", data_rr, model_read(rr_addr));
      check("cyc_data_rd", data_rd, model_read(rd_addr));
      check("cyc_wb_ready", wb_ready, rst && (m_pend.size() == 0));
      check("cyc_sreg", sreg, m_sreg);
      check("cyc_ci", ci, m_sreg[0]);
    end
  end

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #2;
  endtask

  task automatic drive(input logic v, input logic w, input logic [4:0] a, input logic [15:0] d,
                       input logic fwe, input logic co, input logic zo, input logic no);
    wb_valid = v; wb_wide = w; wb_addr = a; wb_data = d;
    wb_flag_we = fwe; alu_co = co; alu_zo = zo; alu_no = no;
  endtask

  task automatic idle();
    drive(1'b0, 1'b0, 5'd0, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    #1 rst = 1'b0;
    #2;
    check("rst_wb_ready", wb_ready, 1'b0);
    check("rst_data_rr", data_rr, 8'h00);
    check("rst_data_rd", data_rd, 8'h00);
    check("rst_ci", ci, 1'b0);
    cmp_en = 1'b1;
    next_cycle();
    next_cycle();
    rst = 1'b1;
    settle();

    // Reset release: every register reads zero, sreg clear, ready high.
    for (int i = 0; i < 32; i++) begin
      rr_addr = 5'(i);
      rd_addr = 5'(31 - i);
      #1;
      check("init_rr", data_rr, 8'h00);
      check("init_rd", data_rd, 8'h00);
    end
    check("init_sreg", sreg, 8'h00);
    check("init_ready", wb_ready, 1'b1);

    // 8-bit accept with bypass, N flag set.
    next_cycle();
    drive(1'b1, 1'b0, 5'd5, 16'h00A5, 1'b1, 1'b0, 1'b0, 1'b1);
    rd_addr = 5'd5;
    settle();
    check("byp_data_rd", data_rd, 8'hA5);
    next_cycle();
    idle();
    settle();
    check("r5_after", data_rd, 8'hA5);
    check("sreg_n", sreg, 8'h04);

    // Wide 0x0010: R0 on edge 1, ready low one cycle, R1 on edge 2.
    next_cycle();
    drive(1'b1, 1'b1, 5'd9, 16'h0010, 1'b0, 1'b0, 1'b0, 1'b0);
    rr_addr = 5'd0; rd_addr = 5'd1;
    settle();
    check("wide_acc_ready", wb_ready, 1'b1);
    check("wide_byp_r0", data_rr, 8'h10);
    next_cycle();
    idle();
    settle();
    check("wide_hi_ready", wb_ready, 1'b0);
    check("wide_r0", data_rr, 8'h10);
    check("wide_byp_r1", data_rd, 8'h00);
    next_cycle();
    settle();
    check("wide_done_ready", wb_ready, 1'b1);
    check("wide_r1", data_rd, 8'h00);

    // Wide 0xBEEF.
    next_cycle();
    drive(1'b1, 1'b1, 5'd0, 16'hBEEF, 1'b0, 1'b0, 1'b0, 1'b0);
    next_cycle();
    idle();
    settle();
    check("beef_r0", data_rr, 8'hEF);
    check("beef_byp_r1", data_rd, 8'hBE);
    next_cycle();
    settle();
    check("beef_r1", data_rd, 8'hBE);

    // Valid held across WR_HI: the 8-bit op lands only after WR_HI.
    drive(1'b1, 1'b1, 5'd0, 16'h1234, 1'b0, 1'b0, 1'b0, 1'b0);
    next_cycle();
    drive(1'b1, 1'b0, 5'd7, 16'h003C, 1'b0, 1'b0, 1'b0, 1'b0);
    rr_addr = 5'd7; rd_addr = 5'd1;
    settle();
    check("hold_ready_lo", wb_ready, 1'b0);
    check("hold_r7_old", data_rr, 8'h00);
    check("hold_byp_r1", data_rd, 8'h12);
    next_cycle();
    settle();
    check("hold_ready_hi", wb_ready, 1'b1);
    check("hold_byp_r7", data_rr, 8'h3C);
    next_cycle();
    idle();
    settle();
    check("hold_r7", data_rr, 8'h3C);
    check("hold_r1", data_rd, 8'h12);

    // Flag write disabled leaves sreg alone.
    drive(1'b1, 1'b0, 5'd9, 16'h0001, 1'b1, 1'b1, 1'b0, 1'b0);
    next_cycle();
    drive(1'b1, 1'b0, 5'd10, 16'h0000, 1'b0, 1'b0, 1'b1, 1'b1);
    settle();
    check("c_set_sreg", sreg, 8'h01);
    next_cycle();
    idle();
    settle();
    check("nofwe_sreg", sreg, 8'h01);
    check("nofwe_ci", ci, 1'b1);

    // Reset during WR_HI drops the pending R1 write and clears R0.
    drive(1'b1, 1'b1, 5'd0, 16'hBEEF, 1'b0, 1'b0, 1'b0, 1'b0);
    rr_addr = 5'd0; rd_addr = 5'd1;
    next_cycle();
    idle();
    rst = 1'b0;
    settle();
    check("wrhi_rst_ready", wb_ready, 1'b0);
    check("wrhi_rst_rr", data_rr, 8'h00);
    check("wrhi_rst_ci", ci, 1'b0);
    next_cycle();
    rst = 1'b1;
    settle();
    check("wrhi_rel_ready", wb_ready, 1'b1);
    check("wrhi_rel_r0", data_rr, 8'h00);
    check("wrhi_rel_r1", data_rd, 8'h00);

    // Randomized traffic, with occasional resets.
    for (int c = 0; c < 1500; c++) begin
      next_cycle();
      if (!rst) begin
        rst = 1'b1;
      end else if ($urandom_range(0, 99) == 0) begin
        rst = 1'b0;
      end
      drive($urandom_range(0, 9) < 7, $urandom_range(0, 4) == 0, 5'($urandom),
            16'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
      rr_addr = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, 1)) : 5'($urandom);
      rd_addr = ($urandom_range(0, 3) == 0) ? wb_addr : 5'($urandom);
    end
    next_cycle();
    idle();
    rst = 1'b1;
    next_cycle();
    next_cycle();
    cmp_en = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/proj1_wb_regfile.md
PROJ1_WB_REGFILE -- requirements
Module: proj1_wb_regfile

Interface
REQ-001 SHALL have one clock and one reset: clk is the single clock, and reset is asynchronous and active-low.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 rst  input  1  asynchronous, active-low reset.
REQ-004 rr_addr  input  5  source register index for the ALU rr operand.
REQ-005 rd_addr  input  5  destination/source register index for the ALU rd operand.
REQ-006 data_rr  output  8  contents of register rr_addr, with bypass.
REQ-007 data_rd  output  8  contents of register rd_addr, with bypass.
REQ-008 ci  output  1  carry input to the ALU; equals SREG C.
REQ-009 wb_valid  input  1  ALU result is presented for writeback.
REQ-010 wb_ready  output  1  block accepts a writeback this cycle.
REQ-011 wb_addr  input  5  destination register for an 8-bit writeback.
REQ-012 wb_wide  input  1  result is 16-bit (multiply) and is written to R1:R0.
REQ-013 wb_data  input  16  ALU result; only bits [7:0] are used when wb_wide=0.
REQ-014 wb_flag_we  input  1  update SREG from the ALU flags on accept.
REQ-015 alu_co / alu_zo / alu_no  input  1 each  ALU carry, zero and negative flags.
REQ-016 sreg  output  8  status register: bit0 C, bit1 Z, bit2 N, bits[7:3] always 0.

Function
REQ-017 SHALL hold 32 x 8-bit registers (R0..R31) and a single write port.
REQ-018 Read paths SHALL be combinational from the address inputs and the current register contents.
REQ-019 Bypass: if a read address matches the register being written in this cycle, the read SHALL return the write data.
REQ-020 The FSM SHALL have two states: IDLE and WR_HI.
REQ-021 IDLE: wb_ready=1; an accept is wb_valid && wb_ready.
REQ-022 Accept with wb_wide=0: write wb_data[7:0] to R[wb_addr] at the clock edge; stay in IDLE.
REQ-023 Accept with wb_wide=1: write wb_data[7:0] to R0; latch wb_data[15:8] into hi_hold; go to WR_HI.
REQ-024 WR_HI: wb_ready=0; write hi_hold to R1; return to IDLE on the next edge (fixed latency: 2 cycles per wide writeback).
REQ-025 wb_valid asserted while wb_ready=0 SHALL be ignored, with no write and no flag update; the upstream holds its data.
REQ-026 SREG SHALL update on accept only when wb_flag_we=1: C<=alu_co, Z<=alu_zo, N<=alu_no, with the flags sampled in the accept cycle.
REQ-027 An SREG update SHALL take effect on ci/sreg in the cycle after the accept; there is no flag bypass.
REQ-028 An 8-bit write to R0 or R1 SHALL behave identically to a write to any other register.
REQ-029 Back-to-back 8-bit accepts SHALL sustain one write per cycle.
REQ-030 wb_addr SHALL be ignored when wb_wide=1.

Reset
REQ-031 Asserting rst low SHALL immediately clear R0..R31, SREG, and hi_hold to 0, and force the FSM to IDLE.
REQ-032 During reset: wb_ready=0, data_rr=0, data_rd=0, ci=0.
REQ-033 A reset asserted while in WR_HI SHALL discard the pending R1 write; R0 is cleared as well.
REQ-034 After rst deasserts, the first accept SHALL be possible at the first rising clk edge.

Structure
REQ-035 Package proj1_pkg SHALL contain: the FSM state enum (IDLE, WR_HI), the SREG bit index constants (SREG_C=0, SREG_Z=1, SREG_N=2), MULT_LO_ADDR=0, MULT_HI_ADDR=1, and the register count of 32.
REQ-036 Storage SHALL be a single sub-module, proj1_regfile (32x8, two combinational read ports, one synchronous write port, asynchronous active-low clear).
REQ-037 The FSM, hi_hold, SREG, and the bypass muxes SHALL reside in proj1_wb_regfile.

Verification
REQ-038 Reset release, then read all of R0..R31 -> all read 0x00, sreg=0x00, wb_ready=1.
REQ-039 8-bit accept (wb_addr=5, wb_data=0x00A5, wb_flag_we=1, alu_no=1), with rd_addr=5 in the same cycle -> data_rd=0xA5 via bypass; next cycle R5=0xA5, sreg=0x04.
REQ-040 Wide accept with wb_data=0x0010 (4x4) -> R0=0x10 after edge 1, wb_ready=0 for one cycle, R1=0x00 after edge 2; wb_data=0xBEEF -> R0=0xEF, R1=0xBE.
REQ-041 wb_valid held high across WR_HI with a second 8-bit op (R7=0x3C) -> that op is accepted only in the cycle after WR_HI; R7=0x3C and R1 intact.
REQ-042 Accept with wb_flag_we=0 while sreg=0x01 -> sreg stays 0x01 and ci stays 1.
REQ-043 rst asserted in WR_HI after a 0xBEEF wide accept -> R0=R1=0x00, state IDLE, wb_ready=1 after release.
